// File: rtl/retire_buffer.sv
// rtl/retire_buffer.sv - in-order retirement buffer with multi-port completion and multi-wide retire
module retire_buffer #(
  parameter int DEPTH    = 64,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int TAG_W    = 6,
  parameter int NUM_WB   = 4,
  parameter int RETIRE_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      enq_valid,
  input  logic                      enq_has_rd,
  input  logic [TAG_W-1:0]          enq_old_tag,
  output logic                      enq_ready,
  output logic [IDX_W-1:0]          enq_index,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]   wb_index,
  output logic [RETIRE_W-1:0]       ret_valid,
  output logic [RETIRE_W-1:0]       ret_free_valid,
  output logic [RETIRE_W*TAG_W-1:0] ret_old_tag,
  output logic [IDX_W:0]            count,
  output logic                      empty
);

  logic [IDX_W:0]     head;
  logic [IDX_W:0]     tail;
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   done_q;
  logic [DEPTH-1:0]   has_rd_q;
  logic [TAG_W-1:0]   tag_q [DEPTH];

  logic               full;
  logic               enq_fire;
  logic               chain;
  logic [IDX_W-1:0]   ret_idx [RETIRE_W];
  logic [RETIRE_W-1:0] run_ok;
  logic [IDX_W:0]     run_len;

  assign full      = (head[IDX_W] != tail[IDX_W]) && (head[IDX_W-1:0] == tail[IDX_W-1:0]);
  assign enq_ready = !full;
  assign enq_index = tail[IDX_W-1:0];
  assign enq_fire  = enq_valid && !full;
  assign empty     = (count == '0);

  // The retire run stops at the first entry from head that is not both valid and done.
  always_comb begin
    chain   = 1'b1;
    run_ok  = '0;
    run_len = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      ret_idx[i] = head[IDX_W-1:0] + IDX_W'(i);
      chain      = chain && valid_q[ret_idx[i]] && done_q[ret_idx[i]];
      run_ok[i]  = chain;
      if (chain) run_len = run_len + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      ret_valid      <= '0;
      ret_free_valid <= '0;
      ret_old_tag    <= '0;
    end else if (flush) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      ret_valid      <= '0;
      ret_free_valid <= '0;
      ret_old_tag    <= '0;
    end else begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && valid_q[wb_index[k*IDX_W +: IDX_W]])
          done_q[wb_index[k*IDX_W +: IDX_W]] <= 1'b1;
      end
      for (int i = 0; i < RETIRE_W; i++) begin
        if (run_ok[i]) valid_q[ret_idx[i]] <= 1'b0;
        ret_valid[i]                   <= run_ok[i];
        ret_free_valid[i]              <= run_ok[i] && has_rd_q[ret_idx[i]];
        ret_old_tag[i*TAG_W +: TAG_W]  <= run_ok[i] ? tag_q[ret_idx[i]] : '0;
      end
      // Enqueue is applied last so it overrides a stray completion to the tail slot.
      if (enq_fire) begin
        valid_q[tail[IDX_W-1:0]] <= 1'b1;
        done_q[tail[IDX_W-1:0]]  <= 1'b0;
        tail                     <= tail + (IDX_W+1)'(1);
      end
      head  <= head + run_len;
      count <= count + (IDX_W+1)'(enq_fire) - run_len;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      has_rd_q[tail[IDX_W-1:0]] <= enq_has_rd;
      tag_q[tail[IDX_W-1:0]]    <= enq_old_tag;
    end
  end

endmodule
